// File: rtl/permutation_pipe.sv
// permutation_pipe: two-stage valid/ready table-driven bit permutation.
// Optional macro PERM_INVERSE_EN builds the per-word inverse mapping.
module permutation_pipe #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 10,
  parameter int IDX_W = 7,
  parameter logic [OUT_W*IDX_W-1:0] P_MAP = {
    7'd3, 7'd5, 7'd2, 7'd7, 7'd4,
    7'd10, 7'd1, 7'd9, 7'd8, 7'd6
  }
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_inv,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data
);

  function automatic int map_at(input int k);
    return int'(P_MAP[(OUT_W-1-k)*IDX_W +: IDX_W]);
  endfunction

  generate
    if (IN_W < 1 || IN_W > 64) begin : g_bad_in_w
      $error("permutation_pipe: IN_W out of range");
    end
    if (OUT_W < 1 || OUT_W > 64) begin : g_bad_out_w
      $error("permutation_pipe: OUT_W out of range");
    end
    if ((64'd1 << IDX_W) <= 64'(IN_W)) begin : g_bad_idx_w
      $error("permutation_pipe: IDX_W too narrow");
    end
    for (genvar g = 0; g < OUT_W; g++) begin : g_chk
      localparam int E = int'(P_MAP[(OUT_W-1-g)*IDX_W +: IDX_W]);
      if (E == 0 || E > IN_W) begin : g_bad_entry
        $error("permutation_pipe: P_MAP entry out of range");
      end
    end
`ifdef PERM_INVERSE_EN
    if (OUT_W != IN_W) begin : g_bad_inv
      $error("permutation_pipe: inverse needs OUT_W == IN_W");
    end
`endif
  endgenerate

  logic             a_valid_q, a_valid_d;
  logic [IN_W-1:0]  a_data_q, a_data_d;
  logic             b_valid_q, b_valid_d;
  logic [OUT_W-1:0] b_data_q, b_data_d;
  logic [OUT_W-1:0] fwd;
  logic [OUT_W-1:0] perm;
  logic             in_fire;
  logic             b_load;
  logic             out_fire;

  assign o_ready  = !a_valid_q || !b_valid_q || i_ready;
  assign in_fire  = i_valid && o_ready;
  assign b_load   = a_valid_q && (!b_valid_q || i_ready);
  assign out_fire = b_valid_q && i_ready;

  // Table is constant, so the compare loops fold to plain wiring.
  always_comb begin
    fwd = '0;
    for (int k = 0; k < OUT_W; k++) begin
      for (int i = 0; i < IN_W; i++) begin
        if (map_at(k) == i + 1) begin
          fwd[OUT_W-1-k] = a_data_q[IN_W-1-i];
        end
      end
    end
  end

`ifdef PERM_INVERSE_EN
  logic             a_inv_q, a_inv_d;
  logic [OUT_W-1:0] inv;

  always_comb begin
    inv = '0;
    for (int k = 0; k < OUT_W; k++) begin
      for (int j = 0; j < OUT_W; j++) begin
        if (map_at(k) == j + 1) begin
          inv[OUT_W-1-j] = a_data_q[IN_W-1-k];
        end
      end
    end
  end

  always_comb begin
    a_inv_d = a_inv_q;
    if (in_fire) begin
      a_inv_d = i_inv;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_inv_q <= 1'b0;
    end else begin
      a_inv_q <= a_inv_d;
    end
  end

  assign perm = a_inv_q ? inv : fwd;
`else
  logic unused_inv;
  assign unused_inv = i_inv;
  assign perm = fwd;
`endif

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    if (in_fire) begin
      a_valid_d = 1'b1;
      a_data_d  = i_data;
    end else if (b_load) begin
      a_valid_d = 1'b0;
    end
    if (b_load) begin
      b_valid_d = 1'b1;
      b_data_d  = perm;
    end else if (out_fire) begin
      b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
    end
  end

  assign o_valid = b_valid_q;
  assign o_data  = b_data_q;

endmodule
